// File: rtl/tt_rand_pkg.sv
// Shared constants and helpers for the LFSR random byte generator.
// Imported by the LFSR core and the tt_um_example top.
package tt_rand_pkg;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  localparam logic [7:0]  MAX_DEFAULT  = 8'hFF;

  localparam int UIO_LOAD_LO = 0;
  localparam int UIO_LOAD_HI = 1;
  localparam int UIO_RUN     = 2;
  localparam int UIO_STEP    = 3;
  localparam int UIO_SET_MAX = 4;
  localparam int UIO_BOUNDED = 5;
  localparam int UIO_NEW_VAL = 6;
  localparam int UIO_PARITY  = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'b1100_0000;

  // One right-shifting Galois step
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // Map a byte into 0..mx via (v * (mx+1)) >> 8
  function automatic logic [7:0] scale(input logic [7:0] v,
                                       input logic [7:0] mx);
    logic [8:0]  m;
    logic [16:0] p;
    m = {1'b0, mx} + 9'd1;
    p = {9'd0, v} * {8'd0, m};
    return 8'(p >> 8);
  endfunction

endpackage

// File: rtl/rand_lfsr16.sv
// 16-bit Galois LFSR with byte-wise seed loading.
// A load that would yield all-zero falls back to the default seed.
module rand_lfsr16
  import tt_rand_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic [7:0]  data,
  input  logic        adv,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic [15:0] loaded;

  // Next state: load has priority over advance
  always_comb begin
    loaded  = state_q;
    state_d = state_q;
    if (load_lo) loaded[7:0]  = data;
    if (load_hi) loaded[15:8] = data;
    if (load_lo || load_hi)
      state_d = (loaded == 16'h0000) ? SEED_DEFAULT : loaded;
    else if (adv)
      state_d = lfsr_next(state_q);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED_DEFAULT;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/tt_um_example.sv
// Random byte generator top: step edge detect, bound scaling,
// registered output byte with new-value strobe and parity.
module tt_um_example
  import tt_rand_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic        rst;
  logic        load_lo;
  logic        load_hi;
  logic        run;
  logic        step;
  logic        set_max;
  logic        bounded;
  logic        step_rise;
  logic        adv;
  logic [15:0] lfsr_state;
  logic [7:0]  nxt_lo;
  logic        unused_ok;

  logic       step_q, step_d;
  logic [7:0] max_q, max_d;
  logic [7:0] uo_q, uo_d;
  logic       new_val_q, new_val_d;

  // The harness name is kept, but this reset is active-high
  assign rst     = rst_n;
  assign load_lo = uio_in[UIO_LOAD_LO];
  assign load_hi = uio_in[UIO_LOAD_HI];
  assign run     = uio_in[UIO_RUN];
  assign step    = uio_in[UIO_STEP];
  assign set_max = uio_in[UIO_SET_MAX];
  assign bounded = uio_in[UIO_BOUNDED];

  assign step_rise = step & ~step_q;
  assign adv = ~(load_lo | load_hi) & (run | step_rise);

  rand_lfsr16 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_lo (load_lo),
    .load_hi (load_hi),
    .data    (ui_in),
    .adv     (adv),
    .state   (lfsr_state)
  );

  assign nxt_lo = 8'(lfsr_next(lfsr_state));

  // Output byte, bound register and strobe next-state
  always_comb begin
    step_d    = step;
    max_d     = set_max ? ui_in : max_q;
    new_val_d = adv;
    uo_d      = uo_q;
    if (adv)
      uo_d = bounded ? scale(nxt_lo, max_q) : nxt_lo;
  end

  // Registers
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q    <= 1'b0;
      max_q     <= MAX_DEFAULT;
      uo_q      <= 8'h00;
      new_val_q <= 1'b0;
    end else begin
      step_q    <= step_d;
      max_q     <= max_d;
      uo_q      <= uo_d;
      new_val_q <= new_val_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = {^uo_q, new_val_q, 6'b00_0000};
  assign uio_oe  = UIO_OE_VAL;

  assign unused_ok = ^{ena, uio_in[7:6]};

endmodule

// File: tb/tb_tt_um_example.sv
// Scoreboard bench for tt_um_example: reference model pushes
// expected results; a monitor pops and compares every cycle.
module tb_tt_um_example;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_example dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  typedef struct {
    int unsigned lfsr;
    int unsigned uo;
    bit          nv;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned m_lfsr = 16'hACE1;
  int unsigned m_max  = 255;
  int unsigned m_uo   = 0;
  bit          m_nv   = 0;
  bit          m_sprev = 0;

  task automatic chk(input string nm, input int unsigned act,
                     input int unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int unsigned par(input int unsigned v);
    int unsigned p = 0;
    for (int i = 0; i < 8; i++) p ^= (v >> i) & 1;
    return p;
  endfunction

  // Drive one cycle at the falling edge and predict the result
  task automatic drive(input bit rst, input bit lo, input bit hi,
                       input bit run, input bit stp, input bit smax,
                       input bit bnd, input int unsigned data);
    bit rise;
    bit adv;
    int unsigned t;
    exp_t e;
    @(negedge clk);
    rst_n  = rst;
    ui_in  = data[7:0];
    uio_in = {2'b00, bnd, smax, stp, run, hi, lo};
    if (rst) begin
      m_lfsr = 16'hACE1;
      m_max = 255;
      m_uo = 0;
      m_nv = 0;
      m_sprev = 0;
    end else begin
      rise = stp && !m_sprev;
      adv = !(lo || hi) && (run || rise);
      if (lo || hi) begin
        t = m_lfsr;
        if (lo) t = (t & 16'hFF00) | (data & 255);
        if (hi) t = (t & 16'h00FF) | ((data & 255) << 8);
        m_lfsr = (t == 0) ? 16'hACE1 : t;
      end else if (adv) begin
        m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr % 2) ? 16'hB400 : 0);
        if (bnd) m_uo = ((m_lfsr % 256) * (m_max + 1)) / 256;
        else m_uo = m_lfsr % 256;
      end
      m_nv = adv;
      if (smax) m_max = data & 255;
      m_sprev = stp;
    end
    e.lfsr = m_lfsr;
    e.uo = m_uo;
    e.nv = m_nv;
    exp_q.push_back(e);
  endtask

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT against each predicted cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_uo_out", uo_out, e.uo);
        chk("sb_uio_out", uio_out, (par(e.uo) << 7) | (e.nv << 6));
        chk("sb_lfsr", dut.u_lfsr.state, e.lfsr);
      end
    end
  end

  initial begin
    int unsigned d;
    chk("uio_oe", uio_oe, 8'hC0);
    // reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_lfsr", dut.u_lfsr.state, 16'hACE1);
    chk("rst_nv", uio_out[6], 0);
    // single step
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    settle();
    chk("step_lfsr", dut.u_lfsr.state, 16'hE270);
    chk("step_uo", uo_out, 8'h70);
    chk("step_par", uio_out[7], 1);
    chk("step_nv", uio_out[6], 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("step_nv_off", uio_out[6], 0);
    // run two clocks
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    settle();
    chk("run1_uo", uo_out, 8'h70);
    chk("run1_nv", uio_out[6], 1);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    settle();
    chk("run2_uo", uo_out, 8'h38);
    chk("run2_nv", uio_out[6], 1);
    // bounded with max 5
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 5);
    drive(0, 0, 0, 0, 1, 0, 1, 0);
    settle();
    chk("bound_uo", uo_out, 8'h02);
    // zero load falls back to seed, output held
    drive(0, 1, 1, 0, 0, 0, 0, 0);
    settle();
    chk("zload_lfsr", dut.u_lfsr.state, 16'hACE1);
    chk("zload_uo", uo_out, 8'h02);
    chk("zload_nv", uio_out[6], 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    settle();
    chk("zload_step", uo_out, 8'h70);
    // loads suppress run
    drive(0, 0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0, 1);
    settle();
    chk("ld_noadv", dut.u_lfsr.state, 16'h0001);
    chk("ld_nv", uio_out[6], 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    settle();
    chk("ld_adv_lfsr", dut.u_lfsr.state, 16'hB400);
    chk("ld_adv_uo", uo_out, 8'h00);
    chk("ld_adv_par", uio_out[7], 0);
    // held step advances once
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 0, 0, 0);
    settle();
    chk("hold_lfsr", dut.u_lfsr.state, 16'h5A00);
    // reset mid-run
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 1, 1, 1, 8'h33);
    settle();
    chk("midrst_uo", uo_out, 8'h00);
    chk("midrst_lfsr", dut.u_lfsr.state, 16'hACE1);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1,
            d);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    #2;
    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_example.md
TT_UM_EXAMPLE -- requirements
Module: tt_um_example

Interface
REQ-001 The port `clk` SHALL be an input, 1 bit wide, and SHALL be the single clock; all state changes on its rising edge.
REQ-002 The port `rst_n` SHALL be an input, 1 bit wide, and SHALL be the synchronous, active-high reset. The harness port name is retained; reset is asserted when `rst_n` = 1.
REQ-003 The port `ena` SHALL be an input, 1 bit wide; it is the harness enable and SHALL be ignored.
REQ-004 The port `ui_in` SHALL be an input, 8 bits wide, carrying the data byte (seed byte or bound value).
REQ-005 The port `uio_in` SHALL be an input, 8 bits wide, with these control bits:
- [0] `load_lo`
- [1] `load_hi`
- [2] `run`
- [3] `step`
- [4] `set_max`
- [5] `bounded`
- [7:6] unused
REQ-006 The port `uo_out` SHALL be an output, 8 bits wide, carrying the registered random value.
REQ-007 The port `uio_out` SHALL be an output, 8 bits wide:
- [6] `new_val` strobe
- [7] parity of `uo_out`
- [5:0] SHALL be 0
REQ-008 The port `uio_oe` SHALL be an output, 8 bits wide, with constant value 8'b1100_0000.

Function
REQ-009 The generator SHALL be a 16-bit Galois LFSR, shifting right, with taps mask 0xB400 (x^16+x^14+x^13+x^11+1).
REQ-010 The next-state rule SHALL be: next = (s>>1) ^ (s[0] ? 0xB400 : 0).
REQ-011 `load_lo`=1 SHALL set LFSR[7:0] to `ui_in`; `load_hi`=1 SHALL set LFSR[15:8] to `ui_in`; both may load in the same cycle.
REQ-012 If a load would leave the LFSR at 0x0000, the LFSR SHALL take 0xACE1 instead (no lock-up state).
REQ-013 An advance SHALL occur in a cycle where (`run`=1 OR a `step` rising edge is detected) AND no load is active. Load has priority; a suppressed advance is dropped, not queued.
REQ-014 `step` edge detection SHALL use a registered copy of `step`; one advance per 0->1 transition.
REQ-015 On an advance edge: the LFSR SHALL take the next state, and `uo_out` SHALL take f(next state) on the same edge (latency 1 clock from request).
REQ-016 f SHALL be: `bounded`=0 -> next[7:0]; `bounded`=1 -> (next[7:0] * (max+1)) >> 8, using a 9-bit multiplier operand and a 17-bit product, so the result is in 0..max.
REQ-017 `set_max`=1 SHALL latch `ui_in` into the 8-bit register max. This is independent of loads and advances.
REQ-018 `new_val` SHALL be 1 for exactly the cycle after each advance edge, and 0 otherwise, including after loads.
REQ-019 `uio_out`[7] SHALL be the XOR-reduction of `uo_out`, computed combinationally.
REQ-020 A load SHALL NOT change `uo_out`.
REQ-021 `bounded` SHALL be sampled only on an advance edge; toggling it alone SHALL NOT change `uo_out`.

Reset
REQ-022 While reset is asserted, the LFSR SHALL be 0xACE1, max 0xFF, `uo_out` 0x00, `new_val` 0, and the step-edge register 0.
REQ-023 Reset SHALL override load, advance and `set_max` in the same cycle; reset mid-run SHALL return to the REQ-022 values on the next edge.

Structure
REQ-024 A shared package `tt_rand_pkg` SHALL hold:
- `LFSR_TAPS` = 0xB400
- `SEED_DEFAULT` = 0xACE1
- `MAX_DEFAULT` = 0xFF
- `uio` bit-index constants
- `UIO_OE_VAL`
REQ-025 One sub-module, `rand_lfsr16`, SHALL be used, with clk, rst, load_lo, load_hi, data, adv and state[15:0] ports; the top holds step edge detection, max, scaling and the output registers.

Verification
REQ-026 Reset, then a single `step` pulse -> after 1 clock: LFSR 0xE270, `uo_out` 0x70, `uio_out`[7] 1, `new_val` high for one cycle.
REQ-027 Reset, then `run`=1 for 2 clocks -> `uo_out` 0x70 then 0x38; `new_val` high both cycles.
REQ-028 Reset, then `set_max` with `ui_in`=0x05, then `bounded`=1 and one `step` -> `uo_out` 0x02.
REQ-029 `load_lo` and `load_hi` with `ui_in`=0x00 -> LFSR 0xACE1; `uo_out` unchanged; next `step` -> 0x70.
REQ-030 `load_lo`=1 with `ui_in`=0x01 and `load_hi` with 0x00 while `run`=1 -> no advance in the load cycle; next advance -> LFSR 0xB400, `uo_out` 0x00, parity 0.
REQ-031 `step` held high for 5 cycles -> exactly one advance; reset asserted mid-run -> `uo_out` 0x00 and LFSR 0xACE1.
